// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a two-entry skid buffer, synchronous flush and
// a saturating stall counter. in_ready is decoded from state only, never from out_ready.
module pipe_stage_skid #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [DATA_W-1:0]   r_m_data;
  logic [CTRL_W-1:0]   r_m_ctrl;
  logic [DATA_W-1:0]   r_s_data;
  logic [CTRL_W-1:0]   r_s_ctrl;
  logic [CNT_W-1:0]    r_stall_cnt;

  logic w_accept;
  logic w_drain;
  logic w_load_m;
  logic w_m_from_s;
  logic w_load_s;
  logic w_stall;

  assign out_valid = (r_state != ST_EMPTY);
  assign in_ready  = (r_state != ST_FULL);
  assign occupancy = r_state;
  assign out_data  = r_m_data;
  // Gating keeps control bits such as MEM_wen from leaking out of a bubble.
  assign out_ctrl  = out_valid ? r_m_ctrl : {CTRL_W{1'b0}};
  assign stall_cnt = r_stall_cnt;

  assign w_accept = in_valid & in_ready;
  assign w_drain  = out_valid & out_ready;
  assign w_stall  = out_valid & ~out_ready;

  always_comb begin
    w_state_next = r_state;
    w_load_m     = 1'b0;
    w_m_from_s   = 1'b0;
    w_load_s     = 1'b0;
    if (flush) begin
      w_state_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_next = ST_ONE;
            w_load_m     = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_drain) begin
            w_load_m = 1'b1;
          end else if (w_accept) begin
            w_state_next = ST_FULL;
            w_load_s     = 1'b1;
          end else if (w_drain) begin
            w_state_next = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_drain) begin
            w_state_next = ST_ONE;
            w_m_from_s   = 1'b1;
          end
        end
        default: w_state_next = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Data registers keep stale contents on flush; only the state forgets them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m_data <= '0;
      r_m_ctrl <= '0;
      r_s_data <= '0;
      r_s_ctrl <= '0;
    end else begin
      if (w_load_m) begin
        r_m_data <= in_data;
        r_m_ctrl <= in_ctrl;
      end else if (w_m_from_s) begin
        r_m_data <= r_s_data;
        r_m_ctrl <= r_s_ctrl;
      end
      if (w_load_s) begin
        r_s_data <= in_data;
        r_s_ctrl <= in_ctrl;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench: a queue model of the stage is compared before every edge,
// a vector table adds hand-computed post-edge expectations.
module tb_pipe_stage_skid;

  localparam int DATA_W = 96;
  localparam int CTRL_W = 6;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic              out_ready = 1'b0;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  logic              sat_in_ready;
  logic              sat_out_valid;
  logic [DATA_W-1:0] sat_out_data;
  logic [CTRL_W-1:0] sat_out_ctrl;
  logic [1:0]        sat_occupancy;
  logic [2:0]        sat_stall_cnt;

  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(3)) u_sat (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(sat_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(sat_out_valid), .out_ready(out_ready), .out_data(sat_out_data),
    .out_ctrl(sat_out_ctrl), .occupancy(sat_occupancy), .stall_cnt(sat_stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
  } entry_t;

  entry_t q[$];
  int     exp_stall;
  int     checks;
  int     errors;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare against the model, advance the model with the driven inputs, then clock.
  task automatic step();
    logic   m_ir;
    logic   acc;
    logic   drn;
    entry_t e;
    m_ir = (q.size() < 2);
    chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
    chk("in_ready", 128'(in_ready), 128'(m_ir));
    chk("occupancy", 128'(occupancy), 128'(q.size()));
    if (q.size() > 0) begin
      chk("out_data", 128'(out_data), 128'(q[0].d));
      chk("out_ctrl", 128'(out_ctrl), 128'(q[0].c));
    end else begin
      chk("out_ctrl_bubble", 128'(out_ctrl), 128'(0));
    end
    chk("stall_cnt", 128'(stall_cnt), 128'(exp_stall > 65535 ? 65535 : exp_stall));
    chk("sat_stall_cnt", 128'(sat_stall_cnt), 128'(exp_stall > 7 ? 7 : exp_stall));
    acc = in_valid & m_ir;
    drn = (q.size() > 0) & out_ready;
    if ((q.size() > 0) && !out_ready) exp_stall++;
    if (flush) begin
      q.delete();
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) begin
        e.d = in_data;
        e.c = in_ctrl;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic fl, input logic ordy,
                       input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
    in_valid  = v;
    flush     = fl;
    out_ready = ordy;
    in_data   = d;
    in_ctrl   = c;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, {12{8'hAA}}, 6'h3F);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_ctrl", 128'(out_ctrl), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_occupancy", 128'(occupancy), 128'(0));
    chk("rst_stall_cnt", 128'(stall_cnt), 128'(0));
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    q.delete();
    exp_stall = 0;
  endtask

  typedef struct {
    logic              v;
    logic              fl;
    logic              ordy;
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
    logic [1:0]        e_occ;
    logic              e_ir;
    int                e_stall;
  } vec_t;

  vec_t tbl[18];

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    exp_stall = 0;

    // A,B into a blocked stage, hold, drain, flush in FULL, accept+drain in ONE, flush in ONE
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 96'hA, 6'h05, 2'd1, 1'b1, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 96'hB, 6'h06, 2'd2, 1'b0, 1};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 96'h0, 6'h00, 2'd2, 1'b0, 2};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 96'h0, 6'h00, 2'd2, 1'b0, 3};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 96'h0, 6'h00, 2'd2, 1'b0, 4};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 96'h0, 6'h00, 2'd2, 1'b0, 5};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 96'h0, 6'h00, 2'd1, 1'b1, 5};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 96'h0, 6'h00, 2'd0, 1'b1, 5};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 96'hC1, 6'h21, 2'd1, 1'b1, 5};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 96'hC2, 6'h22, 2'd2, 1'b0, 6};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 96'hC3, 6'h23, 2'd0, 1'b1, 7};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 96'h0, 6'h00, 2'd0, 1'b1, 7};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 96'hD, 6'h31, 2'd1, 1'b1, 7};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 96'hE, 6'h32, 2'd1, 1'b1, 7};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 96'h0, 6'h00, 2'd0, 1'b1, 7};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 96'hF, 6'h33, 2'd1, 1'b1, 7};
    tbl[16] = '{1'b1, 1'b1, 1'b1, 96'h10, 6'h34, 2'd0, 1'b1, 7};
    tbl[17] = '{1'b0, 1'b0, 1'b1, 96'h0, 6'h00, 2'd0, 1'b1, 7};

    do_reset();

    // Streaming at full throughput
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b0, 1'b1, DATA_W'(i), 6'h21);
      step();
      chk("stream_occ", 128'(occupancy), 128'(1));
      chk("stream_data", 128'(out_data), 128'(i));
      $display("stream word %0d out_data=%0h occ=%0d", i, out_data, occupancy);
    end
    drive(1'b0, 1'b0, 1'b1, '0, '0);
    step();
    step();

    do_reset();
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].v, tbl[i].fl, tbl[i].ordy, tbl[i].d, tbl[i].c);
      step();
      chk("vec_occ", 128'(occupancy), 128'(tbl[i].e_occ));
      chk("vec_in_ready", 128'(in_ready), 128'(tbl[i].e_ir));
      chk("vec_stall", 128'(stall_cnt), 128'(tbl[i].e_stall));
      $display("vec %0d occ=%0d in_ready=%0d stall=%0d out_ctrl=%0h",
               i, occupancy, in_ready, stall_cnt, out_ctrl);
    end

    // Saturation: one entry stalled for 10 cycles
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 96'h55, 6'h01);
    step();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 10; i++) step();
    chk("sat_cnt3", 128'(sat_stall_cnt), 128'(7));
    chk("sat_cnt16", 128'(stall_cnt), 128'(10));
    $display("saturation stall_cnt=%0d sat_stall_cnt=%0d", stall_cnt, sat_stall_cnt);

    // Asynchronous reset between edges while FULL
    drive(1'b1, 1'b0, 1'b0, 96'h66, 6'h02);
    step();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    chk("pre_areset_occ", 128'(occupancy), 128'(2));
    #2;
    reset = 1'b1;
    #1;
    chk("areset_out_valid", 128'(out_valid), 128'(0));
    chk("areset_occ", 128'(occupancy), 128'(0));
    chk("areset_in_ready", 128'(in_ready), 128'(1));
    chk("areset_stall", 128'(stall_cnt), 128'(0));
    chk("areset_out_data", 128'(out_data), 128'(0));
    chk("areset_out_ctrl", 128'(out_ctrl), 128'(0));
    $display("async reset occ=%0d out_valid=%0d stall=%0d", occupancy, out_valid, stall_cnt);
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    exp_stall = 0;
    drive(1'b1, 1'b0, 1'b1, 96'h77, 6'h03);
    step();
    drive(1'b0, 1'b0, 1'b1, '0, '0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
